// File: rtl/rv_pkg.sv
// Shared RISC-V core constants: architectural width, default reset vector,
// and the fixed instruction size used for sequential fetch.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/program_counter.sv
// IF-stage program counter: loads the next-PC mux output on every edge and
// exposes the sequential successor plus an alignment flag.
module program_counter
  import rv_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             misaligned
);

  // Fetch register: no enable, so a stall must be expressed by the mux feeding pc_in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out <= RESET_VECTOR;
    end else begin
      pc_out <= pc_in;
    end
  end

  // Wraps modulo 2^WIDTH; misalignment is reported only, never corrected here
  assign pc_plus4   = pc_out + WIDTH'(INSTR_BYTES);
  assign misaligned = |pc_out[1:0];

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: default and overridden reset vector.
module tb_program_counter;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] pc_in;
    logic [W-1:0] exp_pc;
    logic [W-1:0] exp_plus4;
    logic         exp_mis;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         rst_rv;
  logic [W-1:0] pc_in;
  logic [W-1:0] pc_out, pc_plus4;
  logic         misaligned;
  logic [W-1:0] pc_out_rv, pc_plus4_rv;
  logic         misaligned_rv;

  int checks = 0;
  int errors = 0;

  vec_t vecs [8];

  program_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .misaligned(misaligned)
  );

  program_counter #(.WIDTH(W), .RESET_VECTOR(32'h8000_0000)) dut_rv (
    .clk(clk), .rst(rst_rv), .pc_in(pc_in),
    .pc_out(pc_out_rv), .pc_plus4(pc_plus4_rv), .misaligned(misaligned_rv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input vec_t v);
    chk({name, "_pc"}, pc_out, v.exp_pc);
    chk({name, "_plus4"}, pc_plus4, v.exp_plus4);
    chk({name, "_mis"}, W'(misaligned), W'(v.exp_mis));
  endtask

  // Inputs change 2 ns after an edge; outputs are sampled 1 ns after the next edge.
  task automatic apply_vec(input int i);
    pc_in = vecs[i].pc_in;
    #4;
    chk_all($sformatf("vec%0d", i), vecs[i]);
    #6;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0004, 32'h0000_0004, 32'h0000_0008, 1'b0};
    vecs[1] = '{32'h0000_0008, 32'h0000_0008, 32'h0000_000C, 1'b0};
    vecs[2] = '{32'h0000_000C, 32'h0000_000C, 32'h0000_0010, 1'b0};
    vecs[3] = '{32'h0000_0010, 32'h0000_0010, 32'h0000_0014, 1'b0};
    vecs[4] = '{32'h0000_0014, 32'h0000_0014, 32'h0000_0018, 1'b0};
    vecs[5] = '{32'h0000_0014, 32'h0000_0014, 32'h0000_0018, 1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h0000_0006, 32'h0000_0006, 32'h0000_000A, 1'b1};

    rst = 1'b1;
    rst_rv = 1'b1;
    pc_in = '0;

    #1;  // t=1
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_plus4", pc_plus4, 32'h4);
    chk("rst_mis", W'(misaligned), 32'h0);
    chk("rv_rst_pc", pc_out_rv, 32'h8000_0000);
    chk("rv_rst_plus4", pc_plus4_rv, 32'h8000_0004);

    #11; // t=12
    rst = 1'b0;
    #4;  // t=16, first edge after release loaded pc_in=0
    chk("release_pc", pc_out, 32'h0);

    #6;  // t=22
    for (int i = 0; i < 3; i++) apply_vec(i);

    // t=52: asynchronous reset between edges
    rst = 1'b1;
    #1;  // t=53, before the 55 ns edge
    chk("async_rst_pc", pc_out, 32'h0);
    chk("async_rst_plus4", pc_plus4, 32'h4);
    #3;  // t=56, edge at 55 ignored pc_in=C
    chk("rst_hold_pc", pc_out, 32'h0);
    #6;  // t=62
    rst = 1'b0;
    #4;  // t=66
    chk("resume_pc", pc_out, 32'h0000_000C);
    #6;  // t=72
    for (int i = 3; i < 8; i++) apply_vec(i);

    pc_in = 32'h0000_0008;
    #4;
    chk("align_pc", pc_out, 32'h0000_0008);
    chk("align_mis", W'(misaligned), 32'h0);

    // Overridden vector: held through many edges, then load and re-reset
    chk("rv_hold_pc", pc_out_rv, 32'h8000_0000);
    #6;
    rst_rv = 1'b0;
    #4;
    chk("rv_load_pc", pc_out_rv, 32'h0000_0008);
    #3;
    rst_rv = 1'b1;
    #1;
    chk("rv_async_pc", pc_out_rv, 32'h8000_0000);
    chk("rv_async_plus4", pc_plus4_rv, 32'h8000_0004);
    chk("rv_async_mis", W'(misaligned_rv), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
